dsp_mac_stream: RTL and testbench

// - Pipelined, parametrised multiply-accumulate engine for streaming DSP filters; next-generation DSP slice.
// - Pre-adder (D+/-B), signed multiplier, and an accumulator with saturation over frames of up to ACC_LEN samples.
// - Adds valid/ready flow control on input and output.
// - Sits between a sample source (FIFO or filter tap feeder) and a result consumer, e.g. a cascade or bus interface.

---
 rtl/dsp_mac_stream_if.sv | 30 +++
 rtl/dsp_mac_stream.sv | 127 ++++++++++++
 tb/tb_dsp_mac_stream.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_stream_if.sv
// Stream bundle for dsp_mac_stream: sample input channel and frame result channel.
interface dsp_mac_stream_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48,
  parameter int CW = 5
);
  logic                 IN_VALID;
  logic                 IN_READY;
  logic signed [AW-1:0] A;
  logic signed [BW-1:0] B;
  logic signed [BW-1:0] D;
  logic [2:0]           OPMODE;
  logic                 IN_LAST;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic signed [PW-1:0] P;
  logic                 OVF;
  logic [CW-1:0]        FRAME_CNT;

  modport slave (
    input  IN_VALID, A, B, D, OPMODE, IN_LAST, OUT_READY,
    output IN_READY, OUT_VALID, P, OVF, FRAME_CNT
  );

  modport master (
    output IN_VALID, A, B, D, OPMODE, IN_LAST, OUT_READY,
    input  IN_READY, OUT_VALID, P, OVF, FRAME_CNT
  );
endinterface

// File: rtl/dsp_mac_stream.sv
// Streaming pre-add / multiply / accumulate engine with frame-based results.
// Pipeline: S1 input regs, S2 product, S3 product retime, then accumulate.
// One global enable stalls every stage while a result waits for the consumer.
module dsp_mac_stream #(
  parameter int AW      = 18,
  parameter int BW      = 18,
  parameter int PW      = 48,
  parameter int ACC_LEN = 16,
  parameter int SAT_EN  = 1
) (
  input  logic CLK,
  input  logic RST,
  dsp_mac_stream_if.slave bus
);
  localparam int CW  = $clog2(ACC_LEN + 1);
  localparam int PRW = BW + 1;
  localparam int MW  = AW + BW + 1;
  localparam logic signed [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state_q, state_d;

  logic                  v1_q, v1_d, sub1_q, sub1_d, last1_q, last1_d;
  logic signed [AW-1:0]  a1_q, a1_d;
  logic signed [PRW-1:0] pre1_q, pre1_d;
  logic                  v2_q, v2_d, sub2_q, sub2_d, last2_q, last2_d;
  logic signed [MW-1:0]  prod2_q, prod2_d;
  logic                  v3_q, v3_d, sub3_q, sub3_d, last3_q, last3_d;
  logic signed [MW-1:0]  prod3_q, prod3_d;
  logic signed [PW-1:0]  acc_q, acc_d, p_q, p_d;
  logic                  first_q, first_d, ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;
  logic [CW-1:0]         cnt_q, cnt_d, pcnt_q, pcnt_d, fcnt_q, fcnt_d;

  logic                  en, accept, done, ovf_w, last_in;
  logic signed [PW:0]    base_w, pext_w, s_w;
  logic signed [PW-1:0]  res_w;

  assign en            = !(state_q == HOLD && !bus.OUT_READY);
  assign accept        = bus.IN_VALID && en;
  assign done          = en && v3_q && last3_q;
  assign last_in       = bus.IN_LAST || (cnt_q == CW'(ACC_LEN - 1));
  assign bus.IN_READY  = en;
  assign bus.OUT_VALID = (state_q == HOLD);
  assign bus.P         = p_q;
  assign bus.OVF       = ovf_q;
  assign bus.FRAME_CNT = fcnt_q;

  // Accumulate adder on PW+1 bits; overflow shows as the top two bits differing.
  always_comb begin
    base_w = first_q ? '0 : {acc_q[PW-1], acc_q};
    pext_w = (PW+1)'(prod3_q);
    s_w    = sub3_q ? base_w - pext_w : base_w + pext_w;
    ovf_w  = s_w[PW] ^ s_w[PW-1];
    res_w  = s_w[PW-1:0];
    if (ovf_w && SAT_EN != 0) res_w = s_w[PW] ? P_MIN : P_MAX;
  end

  // Result FSM: HOLD while a frame result waits; back-to-back reload keeps HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (done) state_d = HOLD;
      HOLD:    if (bus.OUT_READY && !done) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Pipeline, sample counter and accumulator next-state; everything holds when en=0.
  always_comb begin
    v1_d = v1_q; a1_d = a1_q; pre1_d = pre1_q; sub1_d = sub1_q; last1_d = last1_q;
    v2_d = v2_q; prod2_d = prod2_q; sub2_d = sub2_q; last2_d = last2_q;
    v3_d = v3_q; prod3_d = prod3_q; sub3_d = sub3_q; last3_d = last3_q;
    acc_d = acc_q; first_d = first_q; ovf_acc_d = ovf_acc_q; pcnt_d = pcnt_q;
    cnt_d = cnt_q; p_d = p_q; ovf_d = ovf_q; fcnt_d = fcnt_q;
    if (en) begin
      v1_d = accept;
      if (accept) begin
        a1_d    = bus.A;
        pre1_d  = !bus.OPMODE[0] ? PRW'(bus.B) :
                  bus.OPMODE[1]  ? PRW'(bus.D) - PRW'(bus.B) : PRW'(bus.D) + PRW'(bus.B);
        sub1_d  = bus.OPMODE[2];
        last1_d = last_in;
        cnt_d   = last_in ? '0 : cnt_q + 1'b1;
      end
      v2_d = v1_q; prod2_d = MW'(a1_q) * MW'(pre1_q); sub2_d = sub1_q; last2_d = last1_q;
      v3_d = v2_q; prod3_d = prod2_q; sub3_d = sub2_q; last3_d = last2_q;
      if (v3_q) begin
        acc_d     = res_w;
        first_d   = 1'b0;
        ovf_acc_d = ovf_acc_q | ovf_w;
        pcnt_d    = pcnt_q + 1'b1;
        if (last3_q) begin
          p_d       = res_w;
          ovf_d     = ovf_acc_q | ovf_w;
          fcnt_d    = pcnt_q + 1'b1;
          first_d   = 1'b1;
          ovf_acc_d = 1'b0;
          pcnt_d    = '0;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1_q <= 1'b0; a1_q <= '0; pre1_q <= '0; sub1_q <= 1'b0; last1_q <= 1'b0;
      v2_q <= 1'b0; prod2_q <= '0; sub2_q <= 1'b0; last2_q <= 1'b0;
      v3_q <= 1'b0; prod3_q <= '0; sub3_q <= 1'b0; last3_q <= 1'b0;
      acc_q <= '0; first_q <= 1'b1; ovf_acc_q <= 1'b0; pcnt_q <= '0;
      cnt_q <= '0; p_q <= '0; ovf_q <= 1'b0; fcnt_q <= '0;
    end else begin
      v1_q <= v1_d; a1_q <= a1_d; pre1_q <= pre1_d; sub1_q <= sub1_d; last1_q <= last1_d;
      v2_q <= v2_d; prod2_q <= prod2_d; sub2_q <= sub2_d; last2_q <= last2_d;
      v3_q <= v3_d; prod3_q <= prod3_d; sub3_q <= sub3_d; last3_q <= last3_d;
      acc_q <= acc_d; first_q <= first_d; ovf_acc_q <= ovf_acc_d; pcnt_q <= pcnt_d;
      cnt_q <= cnt_d; p_q <= p_d; ovf_q <= ovf_d; fcnt_q <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_dsp_mac_stream.sv
// Directed + golden-model bench for dsp_mac_stream across four parameterisations.
module tb_dsp_mac_stream;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  dsp_mac_stream_if #(.AW(18), .BW(18), .PW(48), .CW(3)) if4 ();
  dsp_mac_stream_if #(.AW(18), .BW(18), .PW(37), .CW(5)) ifs ();
  dsp_mac_stream_if #(.AW(18), .BW(18), .PW(37), .CW(5)) ifw ();
  dsp_mac_stream_if #(.AW(18), .BW(18), .PW(48), .CW(2)) if2 ();

  dsp_mac_stream #(.AW(18), .BW(18), .PW(48), .ACC_LEN(4),  .SAT_EN(1)) u4 (.CLK(CLK), .RST(RST), .bus(if4));
  dsp_mac_stream #(.AW(18), .BW(18), .PW(37), .ACC_LEN(16), .SAT_EN(1)) us (.CLK(CLK), .RST(RST), .bus(ifs));
  dsp_mac_stream #(.AW(18), .BW(18), .PW(37), .ACC_LEN(16), .SAT_EN(0)) uw (.CLK(CLK), .RST(RST), .bus(ifw));
  dsp_mac_stream #(.AW(18), .BW(18), .PW(48), .ACC_LEN(2),  .SAT_EN(1)) u2 (.CLK(CLK), .RST(RST), .bus(if2));

  typedef struct {
    logic signed [17:0] a, b, d;
    logic [2:0]         op;
    int                 n;
    longint             p;
    logic               ovf;
    int                 fc;
  } frame_t;
  frame_t tbl[7];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic put4(input logic v, input logic signed [17:0] a, b, d, input logic [2:0] op, input logic last);
    if4.IN_VALID = v; if4.A = a; if4.B = b; if4.D = d; if4.OPMODE = op; if4.IN_LAST = last;
  endtask

  int lat, idx, stall_left, gaps_bad, nres, last_vc, k;
  logic tin, tout;
  longint got_p[$], exp_q[$];
  int got_fc[$];
  logic signed [17:0] ra, rb, rd;
  logic [2:0] rop;
  longint pre, prod, acc, ep;
  logic signed [17:0] sa[12], sb[12];
  logic [2:0] sop[12];

  initial begin
    tbl[0] = '{a:3,       b:5,       d:0,      op:3'b000, n:4, p:60,      ovf:0, fc:4};
    tbl[1] = '{a:-7,      b:4,       d:10,     op:3'b011, n:2, p:-84,     ovf:0, fc:2};
    tbl[2] = '{a:2,       b:3,       d:4,      op:3'b001, n:4, p:56,      ovf:0, fc:4};
    tbl[3] = '{a:5,       b:6,       d:0,      op:3'b100, n:3, p:-90,     ovf:0, fc:3};
    tbl[4] = '{a:-1,      b:-131072, d:-131072, op:3'b001, n:1, p:262144, ovf:0, fc:1};
    tbl[5] = '{a:-131072, b:-131072, d:131071, op:3'b011, n:4, p:-64'sd137438429184, ovf:0, fc:4};
    tbl[6] = '{a:4,       b:1,       d:9,      op:3'b111, n:4, p:-128,    ovf:0, fc:4};

    put4(0, 0, 0, 0, 0, 0); if4.OUT_READY = 1;
    ifs.IN_VALID = 0; ifs.A = 0; ifs.B = 0; ifs.D = 0; ifs.OPMODE = 0; ifs.IN_LAST = 0; ifs.OUT_READY = 1;
    ifw.IN_VALID = 0; ifw.A = 0; ifw.B = 0; ifw.D = 0; ifw.OPMODE = 0; ifw.IN_LAST = 0; ifw.OUT_READY = 1;
    if2.IN_VALID = 0; if2.A = 0; if2.B = 0; if2.D = 0; if2.OPMODE = 0; if2.IN_LAST = 0; if2.OUT_READY = 1;

    // Reset state
    #2;
    chk("rst_out_valid", if4.OUT_VALID, 0);
    chk("rst_p", if4.P, 0);
    chk("rst_frame_cnt", if4.FRAME_CNT, 0);
    #10 RST = 0;
    tick();
    chk("rst_in_ready", if4.IN_READY, 1);

    // Held result is discarded by an asynchronous reset
    if4.OUT_READY = 0;
    for (int j = 0; j < 4; j++) begin put4(1, 1, 1, 0, 0, 0); tick(); end
    put4(0, 0, 0, 0, 0, 0);
    lat = 0;
    while (!if4.OUT_VALID && lat < 10) begin tick(); lat++; end
    chk("hold_p", if4.P, 4);
    tick();
    chk("hold_in_ready", if4.IN_READY, 0);
    chk("hold_p_stable", if4.P, 4);
    #2 RST = 1; #1;
    chk("async_rst_out_valid", if4.OUT_VALID, 0);
    chk("async_rst_p", if4.P, 0);
    chk("async_rst_ovf", if4.OVF, 0);
    chk("async_rst_frame_cnt", if4.FRAME_CNT, 0);
    #2 RST = 0;
    if4.OUT_READY = 1;
    tick();

    // Partial frame discarded by reset mid-stream
    for (int j = 0; j < 2; j++) begin put4(1, 100, 100, 0, 0, 0); tick(); end
    put4(0, 0, 0, 0, 0, 0);
    tick();
    #2 RST = 1; #2 RST = 0;
    for (int j = 0; j < 5; j++) tick();
    chk("partial_no_result", if4.OUT_VALID, 0);

    // Table-driven frames with latency check
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        put4(1, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].op, (j == tbl[i].n - 1) && (tbl[i].n < 4));
        tick();
      end
      put4(0, 0, 0, 0, 0, 0);
      lat = 0;
      while (!if4.OUT_VALID && lat < 10) begin tick(); lat++; end
      chk($sformatf("frame%0d_latency", i), lat, 3);
      chk($sformatf("frame%0d_p", i), if4.P, tbl[i].p);
      chk($sformatf("frame%0d_ovf", i), if4.OVF, tbl[i].ovf);
      chk($sformatf("frame%0d_frame_cnt", i), if4.FRAME_CNT, tbl[i].fc);
    end
    tick();

    // Consumer stall for 5 cycles while three frames stream back-to-back
    for (int j = 0; j < 12; j++) begin
      sa[j]  = (j < 4) ? 18'sd1 : (j < 8) ? 18'sd3 : -18'sd2;
      sb[j]  = (j < 4) ? 18'sd2 : (j < 8) ? 18'sd3 : 18'sd5;
      sop[j] = (j < 8) ? 3'b000 : 3'b100;
    end
    idx = 0; stall_left = 5;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (if4.OUT_VALID && stall_left > 0) begin if4.OUT_READY = 0; stall_left--; end
      else if4.OUT_READY = 1;
      if (idx < 12) put4(1, sa[idx], sb[idx], 0, sop[idx], 0);
      else          put4(0, 0, 0, 0, 0, 0);
      #1;
      if (!if4.OUT_READY) begin
        chk("stall_in_ready", if4.IN_READY, 0);
        chk("stall_p_stable", if4.P, 8);
      end
      tin  = if4.IN_VALID & if4.IN_READY;
      tout = if4.OUT_VALID & if4.OUT_READY;
      if (tout) begin got_p.push_back(if4.P); got_fc.push_back(int'(if4.FRAME_CNT)); end
      tick();
      if (tin) idx++;
    end
    chk("stall_result_count", got_p.size(), 3);
    if (got_p.size() == 3) begin
      chk("stall_f1_p", got_p[0], 8);
      chk("stall_f2_p", got_p[1], 36);
      chk("stall_f3_p", got_p[2], 40);
      chk("stall_f3_frame_cnt", got_fc[2], 4);
    end
    if4.OUT_READY = 1;

    // Saturating vs wrapping accumulation of 16 maximum positive products
    for (int j = 0; j < 16; j++) begin
      ifs.IN_VALID = 1; ifs.A = -18'sd131072; ifs.B = -18'sd131072;
      ifw.IN_VALID = 1; ifw.A = -18'sd131072; ifw.B = -18'sd131072;
      tick();
    end
    ifs.IN_VALID = 0; ifw.IN_VALID = 0;
    lat = 0;
    while (!ifs.OUT_VALID && lat < 10) begin tick(); lat++; end
    chk("sat_latency", lat, 3);
    chk("sat_p", ifs.P, (64'sd1 <<< 36) - 1);
    chk("sat_ovf", ifs.OVF, 1);
    chk("sat_frame_cnt", ifs.FRAME_CNT, 16);
    chk("wrap_valid", ifw.OUT_VALID, 1);
    chk("wrap_p", ifw.P, 0);
    chk("wrap_ovf", ifw.OVF, 1);
    tick();

    // Continuous random stream, ACC_LEN=2, against a golden model
    k = 0; acc = 0; nres = 0; gaps_bad = 0; last_vc = 0;
    for (int cyc = 0; cyc < 1010; cyc++) begin
      if (if2.OUT_VALID) begin
        if (nres > 0 && cyc - last_vc != 2) gaps_bad++;
        last_vc = cyc;
        nres++;
        if (exp_q.size() > 0) begin
          ep = exp_q.pop_front();
          chk("rand_frame_p", if2.P, ep);
        end else chk("rand_unexpected_result", 1, 0);
      end
      if (cyc < 1000) begin
        ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom); rop = 3'($urandom);
        if2.IN_VALID = 1; if2.A = ra; if2.B = rb; if2.D = rd; if2.OPMODE = rop;
        pre  = !rop[0] ? longint'(rb) : rop[1] ? longint'(rd) - longint'(rb) : longint'(rd) + longint'(rb);
        prod = longint'(ra) * pre;
        if (k == 0) acc = 0;
        acc = rop[2] ? acc - prod : acc + prod;
        if (acc > (64'sd1 <<< 47) - 1) acc = (64'sd1 <<< 47) - 1;
        if (acc < -(64'sd1 <<< 47))    acc = -(64'sd1 <<< 47);
        if (k == 1) exp_q.push_back(acc);
        k = 1 - k;
      end else if2.IN_VALID = 0;
      tick();
    end
    chk("rand_result_count", nres, 500);
    chk("rand_valid_every_2nd", gaps_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
